// File: rtl/adc_pkg.sv
// Shared constants for the ADC sample buffer slice.
package adc_pkg;

   localparam int unsigned ADC_DATA_W    = 12;
   localparam int unsigned ADC_BUF_DEPTH = 16;
   localparam logic [ADC_DATA_W-1:0] ADC_MIDSCALE = 12'h800;

endpackage

// File: rtl/adc_buf_mem.sv
// Simple dual-port sample storage: one write port, one registered read port.
module adc_buf_mem
   import adc_pkg::*;
#(
   parameter  int unsigned DATA_W = ADC_DATA_W,
   parameter  int unsigned DEPTH  = ADC_BUF_DEPTH,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read register holds its last value when no pop is requested.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_sample_buffer.sv
// Queues ADC capture results, one write per rising edge of out_ready.
// ADC_BUF_SIGNED_EN: store samples as two's complement instead of offset binary.
module adc_sample_buffer
   import adc_pkg::*;
#(
   parameter  int unsigned DATA_W = ADC_DATA_W,
   parameter  int unsigned DEPTH  = ADC_BUF_DEPTH,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] adc_out,
   input  logic              out_ready,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   input  logic              clr_ovf
);

   logic              rdy_q;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              full_q, empty_q, ovf_q, ovf_d, rd_valid_q;
   logic              wr_evt, do_wr, do_rd, drop;
   logic [DATA_W-1:0] wdata;

`ifdef ADC_BUF_SIGNED_EN
   assign wdata = {~adc_out[DATA_W-1], adc_out[DATA_W-2:0]};
`else
   assign wdata = adc_out;
`endif

   // A full FIFO still accepts a write when the same cycle frees a slot.
   always_comb begin
      wr_evt   = out_ready & ~rdy_q;
      do_rd    = rd_en & ~empty_q;
      do_wr    = wr_evt & (~full_q | do_rd);
      drop     = wr_evt & full_q & ~do_rd;
      wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      ovf_d    = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // rdy_q resets high so a flag already asserted at release is not a new conversion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q      <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         ovf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         rdy_q      <= out_ready;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= (count_d == (AW+1)'(DEPTH));
         empty_q    <= (count_d == '0);
         ovf_q      <= ovf_d;
         rd_valid_q <= do_rd;
      end
   end

   adc_buf_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (do_wr),
      .waddr_i (wr_ptr_q),
      .wdata_i (wdata),
      .re_i    (do_rd),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   assign rd_valid = rd_valid_q;
   assign count    = count_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Self-checking bench for adc_sample_buffer against a queue-based reference model.
module tb_adc_sample_buffer;
   import adc_pkg::*;

   localparam int unsigned DW = ADC_DATA_W;
   localparam int unsigned DP = ADC_BUF_DEPTH;

   logic          clk, rst;
   logic [DW-1:0] adc_out;
   logic          out_ready, rd_en, clr_ovf;
   logic [DW-1:0] rd_data;
   logic          rd_valid, full, empty, overflow;
   logic [4:0]    count;

   adc_sample_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .adc_out   (adc_out),
      .out_ready (out_ready),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a plain queue of stored samples plus status bits.
   logic [DW-1:0] mq[$];
   bit            m_prev;
   bit            m_ovf;
   logic [DW-1:0] m_rd_data;
   bit            m_rd_valid;

   function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
`ifdef ADC_BUF_SIGNED_EN
      return d ^ ADC_MIDSCALE;
`else
      return d;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("count",    32'(count),    32'(mq.size()));
      check("full",     32'(full),     32'(mq.size() == DP));
      check("empty",    32'(empty),    32'(mq.size() == 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      check("rd_data",  32'(rd_data),  32'(m_rd_data));
   endtask

   task automatic model_reset();
      mq.delete();
      m_prev     = 1'b1;
      m_ovf      = 1'b0;
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
   endtask

   // One clock edge of the model, using the inputs currently driven.
   task automatic model_edge();
      bit wr, rd, drop;
      wr     = out_ready && !m_prev;
      m_prev = out_ready;
      rd     = rd_en && (mq.size() != 0);
      drop   = 1'b0;
      m_rd_valid = rd;
      if (rd) m_rd_data = mq.pop_front();
      if (wr) begin
         if (mq.size() < DP) mq.push_back(stored(adc_out));
         else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
   endtask

   task automatic step(input bit rdy, input logic [DW-1:0] d, input bit rd, input bit clr);
      out_ready = rdy;
      adc_out   = d;
      rd_en     = rd;
      clr_ovf   = clr;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic conv(input logic [DW-1:0] d, input bit rd_first);
      step(1'b1, d, rd_first, 1'b0);
      repeat (3) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      step(1'b0, DW'($urandom), 1'b0, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, DW'($urandom), 1'b1, 1'b0);
      step(1'b0, DW'($urandom), 1'b0, 1'b0);
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1;
      out_ready = 1'b1; adc_out = 12'h5A5; rd_en = 1'b0; clr_ovf = 1'b0;
      model_reset();
      #2;
      check_all();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Flag already high at release: no write.
      repeat (3) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      check("no_write_at_release", 32'(count), 32'd0);
      step(1'b0, 12'h000, 1'b0, 1'b0);

      conv(12'h123, 1'b0);
      conv(12'h456, 1'b0);
      conv(12'h789, 1'b0);
      check("three_conv_count", 32'(count), 32'd3);
      pop(); check("pop1", 32'(rd_data), 32'(stored(12'h123)));
      pop(); check("pop2", 32'(rd_data), 32'(stored(12'h456)));
      pop(); check("pop3", 32'(rd_data), 32'(stored(12'h789)));

      // Overflow on the 17th conversion, then clear and drain.
      for (int i = 0; i < 17; i++) conv(DW'(i * 37 + 5), 1'b0);
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_set", 32'(overflow), 32'd1);
      step(1'b0, 12'h000, 1'b0, 1'b1);
      check("ovf_clr", 32'(overflow), 32'd0);
      for (int i = 0; i < 16; i++) pop();
      check("ovf_last", 32'(rd_data), 32'(stored(DW'(15 * 37 + 5))));

      // Full FIFO with simultaneous write and read.
      for (int i = 0; i < 16; i++) conv(DW'($urandom), 1'b0);
      conv(12'hABC, 1'b1);
      check("full_rw_count", 32'(count), 32'd16);
      check("full_rw_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 16; i++) pop();
      check("full_rw_last", 32'(rd_data), 32'(stored(12'hABC)));

      // Empty FIFO with simultaneous write and read: no fall-through.
      step(1'b1, 12'h321, 1'b1, 1'b0);
      check("empty_rw_valid", 32'(rd_valid), 32'd0);
      check("empty_rw_count", 32'(count), 32'd1);
      step(1'b0, 12'h000, 1'b0, 1'b0);
      pop();
      check("empty_rw_data", 32'(rd_data), 32'(stored(12'h321)));

      conv(ADC_MIDSCALE, 1'b0); pop();
`ifdef ADC_BUF_SIGNED_EN
      check("signed_mid", 32'(rd_data), 32'h000);
      conv(12'h000, 1'b0); pop();
      check("signed_zero", 32'(rd_data), 32'h800);
`else
      check("raw_mid", 32'(rd_data), 32'h800);
`endif

      // Randomized traffic: fill-biased phase then drain-biased phase.
      for (int i = 0; i < 600; i++) begin
         int unsigned rd_pct;
         rd_pct = (i < 300) ? 10 : 55;
         step(($urandom % 3) != 0, DW'($urandom),
              ($urandom % 100) < rd_pct, ($urandom % 16) == 0);
      end

      // Asynchronous reset mid-operation.
      for (int i = 0; i < 5; i++) conv(DW'($urandom), 1'b0);
      step(1'b0, 12'h000, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 60; i++)
         step(($urandom % 2) != 0, DW'($urandom), ($urandom % 2) != 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
